// File: rtl/i2f_conv_if.sv
// i2f_conv_if: request/result handshake bundle for the integer-to-float converter.
interface i2f_conv_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/i2f_conv.sv
// i2f_conv: sequential signed int32 to IEEE-754 single converter.
// One normalization shift per cycle, then a single round-to-nearest-even step.
module i2f_conv (
    input  logic       clk,
    input  logic       rst_n,
    i2f_conv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic        sgn_q, sgn_d;
    logic [4:0]  sh_q, sh_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        rnd;
    logic [23:0] frac_r;
    logic [7:0]  exp_r;
    assign rnd    = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    assign frac_r = {1'b0, mag_q[30:8]} + {23'b0, rnd};
    // a carry out of the fraction leaves frac_r[22:0] at zero and bumps the exponent
    assign exp_r  = 8'd158 - {3'b0, sh_q} + {7'b0, frac_r[23]};
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        sgn_d       = sgn_q;
        sh_d        = sh_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                sgn_d   = bus.in_data[31];
                mag_d   = bus.in_data[31] ? -bus.in_data : bus.in_data;
                sh_d    = 5'd0;
                state_d = (bus.in_data == 32'd0) ? DONE : NORM;
                if (bus.in_data == 32'd0) out_data_d = 32'd0;
            end
            NORM: if (mag_q[31]) state_d = ROUND;
                  else begin
                      mag_d = mag_q << 1;
                      sh_d  = sh_q + 5'd1;
                  end
            ROUND: begin
                out_data_d  = {sgn_q, exp_r, frac_r[22:0]};
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // zero shortcut enters DONE with valid low; it rises one cycle later
                out_valid_d = ~(out_valid_q & bus.out_ready);
                state_d     = (out_valid_q & bus.out_ready) ? IDLE : DONE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mag_q       <= 32'd0;
            sgn_q       <= 1'b0;
            sh_q        <= 5'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            sgn_q       <= sgn_d;
            sh_q        <= sh_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_i2f_conv.sv
// tb_i2f_conv: directed vectors, backpressure/reset sequences and a random run
// checked against an independent int-to-float reference.
module tb_i2f_conv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    i2f_conv_if bus();
    i2f_conv dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        int          lat;
    } vec_t;
    vec_t vecs[12];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] ref_f(input logic [31:0] x);
        logic        s;
        logic [31:0] m;
        logic [63:0] q, rem, half;
        int          p, e, shf;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        m = s ? (~x + 32'd1) : x;
        p = 31;
        while (!m[p]) p--;
        e = 127 + p;
        if (p <= 23) q = {32'b0, m} << (23 - p);
        else begin
            shf  = p - 23;
            q    = {32'b0, m} >> shf;
            rem  = {32'b0, m} & ((64'd1 << shf) - 64'd1);
            half = 64'd1 << (shf - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {s, e[7:0], q[22:0]};
    endfunction
    task automatic send_and_wait(input logic [31:0] x, output int lat, output logic [31:0] d);
        int k;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = bus.out_data;
    endtask
    task automatic handshake(input string name);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, " valid drop"}, {31'b0, bus.out_valid}, 32'd0);
        chk({name, " in_ready back"}, {31'b0, bus.in_ready}, 32'd1);
    endtask
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int          lat, got, sent, cyc, xs;
        logic [31:0] d;
        logic        acc;
        logic [31:0] expq[$];
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
        vecs[0]  = '{32'd1,          32'h3F800000, 33};
        vecs[1]  = '{32'hFFFFFFFF,   32'hBF800000, 33};
        vecs[2]  = '{32'd0,          32'h00000000, 1};
        vecs[3]  = '{32'h7FFFFFFF,   32'h4F000000, 3};
        vecs[4]  = '{32'h80000000,   32'hCF000000, 2};
        vecs[5]  = '{32'd16777217,   32'h4B800000, 9};
        vecs[6]  = '{32'd16777219,   32'h4B800002, 9};
        vecs[7]  = '{32'd16777221,   32'h4B800002, 9};
        vecs[8]  = '{32'd3,          32'h40400000, 32};
        vecs[9]  = '{32'd5,          32'h40A00000, 31};
        vecs[10] = '{32'h00FFFFFF,   32'h4B7FFFFF, 10};
        vecs[11] = '{32'hFFFFFFFE,   32'hC0000000, 32};
        #2;
        chk("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset out_data", bus.out_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            send_and_wait(vecs[i].din, lat, d);
            chk($sformatf("vec%0d data", i), d, vecs[i].dout);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            handshake($sformatf("vec%0d", i));
        end
        send_and_wait(32'd3, lat, d);
        chk("bp data", d, 32'h40400000);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 32'd7;
            end
            if (i == 4) bus.in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("bp hold data %0d", i), bus.out_data, 32'h40400000);
            chk($sformatf("bp hold valid %0d", i), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("bp in_ready %0d", i), {31'b0, bus.in_ready}, 32'd0);
        end
        handshake("bp");
        repeat (40) @(negedge clk);
        chk("bp dropped request", {31'b0, bus.out_valid}, 32'd0);
        chk("bp idle", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst pre busy", {31'b0, bus.in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst async out_data", bus.out_data, 32'd0);
        chk("rst async in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_and_wait(32'd5, lat, d);
        chk("rst then 5 data", d, 32'h40A00000);
        chk("rst then 5 latency", 32'(lat), 32'd31);
        handshake("rst then 5");
        got  = 0;
        sent = 0;
        cyc  = 0;
        acc  = 1'b0;
        while (got < 6000 && cyc < 60000) begin
            bus.out_ready = ($urandom % 8) != 0;
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rand extra result: got %h expected none", bus.out_data);
                end else chk($sformatf("rand %0d", got), bus.out_data, expq.pop_front());
                got++;
            end
            if (!bus.in_valid && sent < 6000) begin
                xs = $urandom;
                if ($urandom % 16 == 0) xs = xs >>> ($urandom % 32);
                bus.in_valid = 1'b1;
                bus.in_data  = xs;
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(ref_f(bus.in_data));
                sent++;
                acc = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                bus.in_valid = 1'b0;
                acc = 1'b0;
            end
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("rand results received", 32'(got), 32'd6000);
        chk("rand requests accepted", 32'(sent), 32'd6000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
